// File: rtl/chu_frame_capture_core.sv
// chu_frame_capture_core: video pixel pass-through with an armable 32x32
// window capture into a dual-port RAM, read back through a register slot.
module chu_frame_capture_core #(
  parameter int CD         = 12,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                state, state_next;
  logic                  partial, partial_next;
  logic [10:0]           x0, y0;
  logic [15:0]           frame_cnt;
  logic [CD-1:0]         ram [2**ADDR_WIDTH];

  logic                  frame_start, reg_sel, rd_en;
  logic                  ctrl_wr, x0_wr, y0_wr, fcnt_wr;
  logic                  cfg_open, busy, done;
  logic [11:0]           x_ext, y_ext, x0_ext, y0_ext, x_hi, y_hi, dx, dy;
  logic                  in_win, cap_on, cap_we, cap_last, fcnt_inc;
  logic [ADDR_WIDTH-1:0] cap_idx, ram_rd_idx;
  logic [31:0]           status_word;
  logic                  unused;

  assign so_rgb = si_rgb;

  assign frame_start = (x == 11'd0) && (y == 11'd0);
  assign reg_sel     = addr[13];
  assign rd_en       = cs && read;
  assign ctrl_wr     = cs && write && reg_sel && (addr[1:0] == 2'b00);
  assign x0_wr       = cs && write && reg_sel && (addr[1:0] == 2'b01);
  assign y0_wr       = cs && write && reg_sel && (addr[1:0] == 2'b10);
  assign fcnt_wr     = cs && write && reg_sel && (addr[1:0] == 2'b11);

  assign busy     = (state == ARMED) || (state == CAPTURE);
  assign done     = (state == DONE);
  assign cfg_open = (state == IDLE) || (state == DONE);

  // Window test in 12 bits so x0+31 never wraps past the 11-bit coordinate range.
  assign x_ext  = {1'b0, x};
  assign y_ext  = {1'b0, y};
  assign x0_ext = {1'b0, x0};
  assign y0_ext = {1'b0, y0};
  assign x_hi   = x0_ext + 12'd31;
  assign y_hi   = y0_ext + 12'd31;
  assign dx     = x_ext - x0_ext;
  assign dy     = y_ext - y0_ext;
  assign in_win = (x_ext >= x0_ext) && (x_ext <= x_hi) &&
                  (y_ext >= y0_ext) && (y_ext <= y_hi);

  // The frame-start pixel that moves ARMED into CAPTURE is itself a capture
  // candidate; a frame start seen while already capturing belongs to the next
  // frame and only ends the capture.
  assign cap_on   = ((state == CAPTURE) && !frame_start) ||
                    ((state == ARMED) && frame_start);
  assign cap_we   = cap_on && in_win;
  assign cap_last = cap_we && (x_ext == x_hi) && (y_ext == y_hi);
  assign cap_idx  = ADDR_WIDTH'({dy[4:0], dx[4:0]});

  assign ram_rd_idx  = addr[ADDR_WIDTH-1:0];
  assign status_word = {29'd0, partial, done, busy};
  assign fcnt_inc    = frame_start &&
                       ((state == CAPTURE) || (state_next == CAPTURE));

  assign unused = ^{wr_data, addr, dx[11:5], dy[11:5]};

  // Next-state logic: natural capture progress, overridden by CTRL writes (abort first).
  always_comb begin
    state_next   = state;
    partial_next = partial;
    case (state)
      ARMED: begin
        if (frame_start) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (frame_start) begin
          state_next   = DONE;
          partial_next = 1'b1;
        end else if (cap_last) begin
          state_next = DONE;
        end
      end
      default: ;
    endcase
    if (ctrl_wr && wr_data[1]) begin
      state_next   = IDLE;
      partial_next = 1'b0;
    end else if (ctrl_wr && wr_data[0] && cfg_open) begin
      state_next   = ARMED;
      partial_next = 1'b0;
    end
  end

  // Control and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      partial   <= 1'b0;
      x0        <= '0;
      y0        <= '0;
      frame_cnt <= '0;
    end else begin
      state   <= state_next;
      partial <= partial_next;
      if (x0_wr && cfg_open) x0 <= wr_data[10:0];
      if (y0_wr && cfg_open) y0 <= wr_data[10:0];
      if (fcnt_wr)       frame_cnt <= '0;
      else if (fcnt_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Capture write port; slot writes never reach the RAM.
  always_ff @(posedge clk) begin
    if (cap_we) ram[cap_idx] <= si_rgb;
  end

  // Registered slot read: RAM read-before-write or register snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (!reg_sel) begin
        rd_data <= 32'(ram[ram_rd_idx]);
      end else begin
        case (addr[1:0])
          2'b00:   rd_data <= status_word;
          2'b01:   rd_data <= 32'(x0);
          2'b10:   rd_data <= 32'(y0);
          default: rd_data <= 32'(frame_cnt);
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chu_frame_capture_core.sv
// Bench for chu_frame_capture_core: register vector table, directed
// capture scenarios and a randomized run against a behavioural model.
module tb_chu_frame_capture_core;

  localparam int CD = 12;
  localparam logic [13:0] A_STAT = 14'h2000;
  localparam logic [13:0] A_X0   = 14'h2001;
  localparam logic [13:0] A_Y0   = 14'h2002;
  localparam logic [13:0] A_FC   = 14'h2003;
  localparam logic [10:0] IX     = 11'd2000;
  localparam int S_IDLE = 0, S_ARMED = 1, S_CAP = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   x = IX, y = IX;
  logic          cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [13:0]   addr = '0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic [CD-1:0] si_rgb = '0;
  logic [CD-1:0] so_rgb;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int            m_st = S_IDLE;
  bit            m_partial = 1'b0;
  int            m_x0 = 0, m_y0 = 0, m_fc = 0;
  logic [31:0]   m_rd = '0;
  bit            m_rd_known = 1'b1;
  logic [CD-1:0] m_mem [1024];
  bit            m_known [1024];

  typedef struct packed {
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [13:0] raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [12];

  chu_frame_capture_core dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
  );

  always #5 clk = ~clk;

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within cycle budget");
    $fatal(1, "timeout");
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [CD-1:0] pix(input int px, input int py, input logic [CD-1:0] salt);
    logic [10:0] a, b;
    a = px[10:0];
    b = py[10:0];
    return {a[5:0], b[5:0]} ^ salt;
  endfunction

  function automatic void model_reset();
    m_st = S_IDLE; m_partial = 1'b0;
    m_x0 = 0; m_y0 = 0; m_fc = 0;
    m_rd = '0; m_rd_known = 1'b1;
  endfunction

  // One clock edge of the specified behaviour, given the inputs seen at that edge.
  function automatic void model_step(input int px, input int py, input bit mcs, input bit mrd,
                                     input bit mwr, input logic [13:0] ma, input logic [31:0] mwd,
                                     input logic [CD-1:0] msi);
    bit fs, regs, cap_on, last, ctrl;
    int r, idx, nst;
    bit npart;
    fs   = (px == 0) && (py == 0);
    regs = ma[13];
    r    = int'(ma[1:0]);
    if (mcs && mrd) begin
      if (!regs) begin
        idx = int'(ma[9:0]);
        m_rd = 32'(m_mem[idx]);
        m_rd_known = m_known[idx];
      end else begin
        m_rd_known = 1'b1;
        case (r)
          0: m_rd = (m_partial ? 32'd4 : 32'd0) | ((m_st == S_DONE) ? 32'd2 : 32'd0) |
                    ((m_st == S_ARMED || m_st == S_CAP) ? 32'd1 : 32'd0);
          1: m_rd = 32'(m_x0);
          2: m_rd = 32'(m_y0);
          default: m_rd = 32'(m_fc);
        endcase
      end
    end
    cap_on = (m_st == S_CAP && !fs) || (m_st == S_ARMED && fs);
    last = 1'b0;
    if (cap_on && px >= m_x0 && px <= m_x0 + 31 && py >= m_y0 && py <= m_y0 + 31) begin
      idx = (py - m_y0) * 32 + (px - m_x0);
      m_mem[idx] = msi;
      m_known[idx] = 1'b1;
      last = (px == m_x0 + 31) && (py == m_y0 + 31);
    end
    nst = m_st;
    npart = m_partial;
    if (m_st == S_ARMED && fs) nst = S_CAP;
    else if (m_st == S_CAP && fs) begin nst = S_DONE; npart = 1'b1; end
    else if (m_st == S_CAP && last) nst = S_DONE;
    ctrl = mcs && mwr && regs && (r == 0);
    if (ctrl && mwd[1]) begin nst = S_IDLE; npart = 1'b0; end
    else if (ctrl && mwd[0] && (m_st == S_IDLE || m_st == S_DONE)) begin nst = S_ARMED; npart = 1'b0; end
    if (mcs && mwr && regs && r == 3) m_fc = 0;
    else if (fs && (m_st == S_CAP || nst == S_CAP)) m_fc = (m_fc + 1) % 65536;
    if (mcs && mwr && regs && (m_st == S_IDLE || m_st == S_DONE)) begin
      if (r == 1) m_x0 = int'(mwd[10:0]);
      if (r == 2) m_y0 = int'(mwd[10:0]);
    end
    m_st = nst;
    m_partial = npart;
  endfunction

  // Drive one cycle's inputs (entered just after a rising edge) and check outputs.
  task automatic cycle(input logic [10:0] cx, input logic [10:0] cy, input logic ccs,
                       input logic crd, input logic cwr, input logic [13:0] ca,
                       input logic [31:0] cwd, input logic [CD-1:0] csi);
    x = cx; y = cy; cs = ccs; read = crd; write = cwr; addr = ca; wr_data = cwd; si_rgb = csi;
    #1;
    check("so_rgb", 32'(so_rgb), 32'(csi));
    model_step(int'(cx), int'(cy), ccs, crd, cwr, ca, cwd, csi);
    @(posedge clk);
    #1;
    if (m_rd_known) check("rd_data_model", rd_data, m_rd);
    cs = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic wr_reg(input logic [13:0] a, input logic [31:0] d);
    cycle(IX, IX, 1'b1, 1'b0, 1'b1, a, d, '0);
  endtask

  task automatic rd_expect(input string name, input logic [13:0] a, input logic [31:0] exp);
    cycle(IX, IX, 1'b1, 1'b1, 1'b0, a, 32'd0, '0);
    check(name, rd_data, exp);
  endtask

  task automatic px_cycle(input int px, input int py, input logic [CD-1:0] si);
    cycle(11'(px), 11'(py), 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, si);
  endtask

  // Frame start followed by the rows/columns around the window (sparse frame).
  task automatic scan(input int wx0, input int wy0, input int fw, input int fh,
                      input logic [CD-1:0] salt);
    int ylo, yhi, xlo, xhi;
    ylo = (wy0 > 0) ? wy0 - 1 : 0;
    yhi = (wy0 + 33 < fh) ? wy0 + 33 : fh - 1;
    xlo = (wx0 > 0) ? wx0 - 1 : 0;
    xhi = (wx0 + 33 < fw) ? wx0 + 33 : fw - 1;
    px_cycle(0, 0, pix(0, 0, salt));
    for (int yy = ylo; yy <= yhi; yy++)
      for (int xx = xlo; xx <= xhi; xx++)
        if (!(xx == 0 && yy == 0)) px_cycle(xx, yy, pix(xx, yy, salt));
  endtask

  initial begin
    vecs[0]  = '{A_X0,    32'h0000_07FF, A_X0,   32'h7FF};
    vecs[1]  = '{A_X0,    32'hFFFF_F805, A_X0,   32'h005};
    vecs[2]  = '{A_Y0,    32'h0000_0123, A_Y0,   32'h123};
    vecs[3]  = '{14'h3FF5, 32'h0000_002A, A_X0,  32'h02A};
    vecs[4]  = '{A_STAT,  32'h2,         A_STAT, 32'h0};
    vecs[5]  = '{A_STAT,  32'h3,         A_STAT, 32'h0};
    vecs[6]  = '{A_FC,    32'hFFFF,      A_FC,   32'h0};
    vecs[7]  = '{A_STAT,  32'h1,         A_STAT, 32'h1};
    vecs[8]  = '{A_X0,    32'h10,        A_X0,   32'h02A};
    vecs[9]  = '{A_Y0,    32'h77,        A_Y0,   32'h123};
    vecs[10] = '{A_STAT,  32'h1,         A_STAT, 32'h1};
    vecs[11] = '{A_STAT,  32'h2,         A_STAT, 32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check("rst_rd_data", rd_data, 32'h0);
    rd_expect("rst_status", A_STAT, 32'h0);
    rd_expect("rst_x0", A_X0, 32'h0);
    rd_expect("rst_y0", A_Y0, 32'h0);
    rd_expect("rst_frame_cnt", A_FC, 32'h0);

    // Register vector table
    for (int i = 0; i < 12; i++) begin
      wr_reg(vecs[i].waddr, vecs[i].wdata);
      rd_expect($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
    end

    // Basic capture of a 32x32 window at (100,50)
    wr_reg(A_X0, 32'd100);
    wr_reg(A_Y0, 32'd50);
    wr_reg(A_STAT, 32'h1);
    scan(100, 50, 640, 480, '0);
    rd_expect("basic_status", A_STAT, 32'h2);
    rd_expect("basic_ram0", 14'd0, 32'd2354);
    rd_expect("basic_ram1023", 14'd1023, 32'd209);
    cycle(IX, IX, 1'b0, 1'b0, 1'b0, 14'd0, 32'd0, '0);
    check("basic_rd_hold", rd_data, 32'd209);
    rd_expect("basic_frame_cnt", A_FC, 32'd1);

    // Arm mid-frame: nothing happens before the next frame start
    wr_reg(A_X0, 32'd10);
    wr_reg(A_Y0, 32'd10);
    wr_reg(A_FC, 32'd0);
    cycle(11'd5, 11'd200, 1'b1, 1'b0, 1'b1, A_STAT, 32'h1, '0);
    for (int xx = 6; xx < 40; xx++) px_cycle(xx, 200, pix(xx, 200, '0));
    rd_expect("midarm_status_armed", A_STAT, 32'h1);
    scan(10, 10, 640, 480, '0);
    rd_expect("midarm_status_done", A_STAT, 32'h2);
    rd_expect("midarm_frame_cnt", A_FC, 32'd1);

    // Off-screen window ends at the next frame start with partial set
    wr_reg(A_X0, 32'd620);
    wr_reg(A_Y0, 32'd470);
    wr_reg(A_STAT, 32'h1);
    scan(620, 470, 640, 480, '0);
    rd_expect("offscr_status_busy", A_STAT, 32'h1);
    px_cycle(0, 0, '0);
    rd_expect("offscr_status", A_STAT, 32'h6);
    rd_expect("offscr_ram0", 14'd0, 32'd2838);
    rd_expect("offscr_ram20_kept", 14'd20, 32'd1930);
    rd_expect("offscr_frame_cnt", A_FC, 32'd3);

    // Locked registers and abort-over-arm
    wr_reg(A_X0, 32'd4);
    wr_reg(A_Y0, 32'd4);
    wr_reg(A_STAT, 32'h1);
    rd_expect("rearm_from_partial", A_STAT, 32'h1);
    px_cycle(0, 0, pix(0, 0, '0));
    px_cycle(4, 4, pix(4, 4, '0));
    px_cycle(5, 4, pix(5, 4, '0));
    wr_reg(A_X0, 32'd5);
    rd_expect("locked_x0", A_X0, 32'd4);
    wr_reg(A_STAT, 32'h3);
    rd_expect("abort_arm_status", A_STAT, 32'h0);

    // Re-arm from DONE overwrites the RAM; slot RAM writes are ignored
    wr_reg(A_X0, 32'd10);
    wr_reg(A_Y0, 32'd10);
    wr_reg(A_STAT, 32'h1);
    scan(10, 10, 640, 480, '0);
    rd_expect("cap1_status", A_STAT, 32'h2);
    wr_reg(A_STAT, 32'h1);
    rd_expect("rearm_status", A_STAT, 32'h1);
    scan(10, 10, 640, 480, 12'h555);
    rd_expect("cap2_status", A_STAT, 32'h2);
    rd_expect("cap2_ram20", 14'd20, 32'd735);
    cycle(IX, IX, 1'b1, 1'b0, 1'b1, 14'd20, 32'd0, '0);
    rd_expect("slot_wr_ignored", 14'd20, 32'd735);

    // Reset in the middle of a capture
    wr_reg(A_STAT, 32'h1);
    px_cycle(0, 0, '0);
    for (int yy = 9; yy <= 20; yy++)
      for (int xx = 9; xx <= 43; xx++) px_cycle(xx, yy, pix(xx, yy, 12'h0F0));
    reset = 1'b1;
    model_reset();
    x = 11'd30; y = 11'd25; si_rgb = '0;
    #1;
    check("midrst_rd_data", rd_data, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int yy = 21; yy <= 43; yy++)
      for (int xx = 9; xx <= 43; xx++) px_cycle(xx, yy, pix(xx, yy, 12'h0F0));
    rd_expect("midrst_status", A_STAT, 32'h0);
    rd_expect("midrst_x0", A_X0, 32'h0);
    rd_expect("midrst_frame_cnt", A_FC, 32'h0);
    rd_expect("midrst_ram_before", 14'd325, 32'd804);
    rd_expect("midrst_ram_after", 14'd500, 32'd716);

    // Randomized run on a 40x36 frame against the model
    for (int f = 0; f < 10; f++) begin
      for (int yy = 0; yy < 36; yy++) begin
        for (int xx = 0; xx < 40; xx++) begin
          logic ccs, crd, cwr;
          logic [13:0] ca;
          logic [31:0] cwd;
          ccs = 1'b0; crd = 1'b0; cwr = 1'b0; ca = '0; cwd = '0;
          if ($urandom % 8 == 0) begin
            case ($urandom % 9)
              0, 1: begin ccs = 1'b1; crd = 1'b1; ca = {12'h800, 2'($urandom % 4)}; end
              2, 3: begin ccs = 1'b1; crd = 1'b1; ca = 14'($urandom % 1024); end
              4: begin ccs = 1'b1; cwr = 1'b1; ca = A_STAT;
                       cwd = ($urandom % 20 == 0) ? 32'($urandom % 2 + 2) : 32'h1; end
              5: begin ccs = 1'b1; cwr = 1'b1; ca = A_X0; cwd = 32'($urandom % 48); end
              6: begin ccs = 1'b1; cwr = 1'b1; ca = A_Y0; cwd = 32'($urandom % 44); end
              7: if ($urandom % 8 == 0) begin ccs = 1'b1; cwr = 1'b1; ca = A_FC; cwd = $urandom; end
              default: begin ccs = 1'b1; cwr = 1'b1; ca = 14'($urandom % 1024); cwd = $urandom; end
            endcase
          end
          cycle(11'(xx), 11'(yy), ccs, crd, cwr, ca, cwd, CD'($urandom));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
